gppcu_instr_issue: RTL and testbench
====================================

// Module: gppcu_instr_issue
// PURPOSE
// - Instruction fetch/issue sequencer that drives the GPPCU instruction decoder.
// - On iSTART it reads a program of iLEN words from instruction memory (addresses 0..iLEN-1).
// - Issues opcode + operand fields one per cycle, with backpressure from the lanes (iSTALL).
// - Sits between the host/control registers and the decoder/lane array.
// PARAMETERS
// - AW         10  instruction memory address width
// - IW         32  instruction word width; opcode = word[IW-1:IW-5]
// - BUF_DEPTH  2   fetch buffer entries (>=2, power of two)
// PORTS
// - iCLK        in   1       clock; all logic on the rising edge
// - iRST_n      in   1       asynchronous, active-low reset
// - iSTART      in   1       1-cycle start pulse; sampled only in IDLE
// - iABORT      in   1       synchronous flush to IDLE; no oDONE
// - iLEN        in   AW+1    program length in words, latched on iSTART
// - oBUSY       out  1       high from the cycle after iSTART until oDONE/abort
// - oDONE       out  1       1-cycle pulse when program fully issued
// - oIMEM_RD    out  1       memory read strobe
// - oIMEM_ADDR  out  AW      read address; data valid next cycle
// - iIMEM_DATA  in   IW      read data, 1-cycle synchronous latency
// - iSTALL      in   1       lanes cannot accept an instruction this cycle
// - oISSUE      out  1       oOPC/oOPERAND/oPC valid and consumed this cycle
// - oOPC        out  5       opcode to decoder; NOP when oISSUE=0
// - oOPERAND    out  IW-5    remaining instruction bits; 0 when oISSUE=0
// - oPC         out  AW      address of issued instruction
// BEHAVIOUR
// - Reset: all outputs 0 (oOPC=NOP=5'd0). State=IDLE. Fetch PC, issue count, buffer and in-flight flag cleared.
// - States:
//   - IDLE: iSTART with iLEN!=0 -> RUN. iSTART with iLEN==0 -> DONE (oDONE pulses next cycle, no fetch).
//   - RUN: -> DONE when issued==len and no word buffered or in flight.
//   - DONE: oDONE=1 for one cycle -> IDLE.
// - Fetch rule:
//   - In RUN, fetch when fpc<len and (count + inflight - pop) < BUF_DEPTH.
//   - A fetch asserts oIMEM_RD, sets oIMEM_ADDR=fpc, then fpc++.
//   - The returning word is written to the buffer the next cycle.
// - Issue rule:
//   - pop = RUN & count!=0 & ~iSTALL. oISSUE=pop; fields are driven from the buffer head.
//   - Outputs are combinational from the head register; there is no extra register stage.
// - Latency and throughput:
//   - First issue occurs 2 cycles after the first oIMEM_RD.
//   - Steady state is 1 instruction/cycle when iSTALL=0.
// - iSTALL: nothing is issued or lost. A word returning during a stall is buffered. Fetch stops once the buffer is full (count + inflight).
// - Multi-cycle ops (FDIV, FSQRT): the lanes hold iSTALL. This block has no opcode knowledge; it passes opcodes through unchanged.
// - iABORT (any state): next cycle IDLE, buffer flushed, in-flight return discarded, oBUSY=0, no oDONE. iABORT beats iSTART in the same cycle.
// - iSTART while not IDLE: ignored.
// - Reset mid-operation: immediate return to reset state; no further oIMEM_RD.
// - Widths: fpc and issued are AW+1 bits, so iLEN = 2^AW is legal. fpc never wraps; no address >= len is ever read.
// STRUCTURE
// - GPPCU_PARAMETERS.vh gets:
//   - opcode localparams (NOP = 5'd0 already present);
//   - OPC_MSB/OPC_LSB field positions;
//   - state encodings ISS_IDLE, ISS_RUN, ISS_DONE.
// - One sub-module, gppcu_issue_fifo:
//   - sync FIFO, BUF_DEPTH x IW, async active-low reset;
//   - ports: push, pop, flush, head, count.
// - The top level holds the FSM, fetch PC, in-flight flag, issue counter and output muxing.
// TESTING
// - Basic run: iLEN=4, mem[0..3] = {32'h08000001, 32'h10000002, 32'h18000003, 32'h00000000}, iSTALL=0.
//   -> oISSUE high 4 consecutive cycles.
//   -> oOPC = 1,2,3,0; oOPERAND = 1,2,3,0; oPC = 0..3.
//   -> oDONE pulses 1 cycle after the last issue; exactly 4 oIMEM_RD.
// - Stall: iLEN=3, iSTALL high for 5 cycles after the first issue.
//   -> no oISSUE during the stall; at most BUF_DEPTH words buffered.
//   -> remaining 2 issue in order after release; no duplicate or dropped oPC.
// - Zero length: iSTART with iLEN=0 -> no oIMEM_RD, oDONE 1 cycle later, oBUSY low.
// - Abort: iABORT asserted with 1 word in flight and 1 buffered.
//   -> next cycle oISSUE=0, oBUSY=0, no oDONE.
//   -> a following iSTART with iLEN=2 reissues from oPC=0.
// - Async reset: drop iRST_n mid-run without a clock edge -> outputs 0 immediately; after release, state is IDLE.
// - Max length: AW=4, iLEN=16, random iSTALL.
//   -> exactly 16 issues with oPC 0..15; oIMEM_ADDR never exceeds 15.

Source files
------------

// File: rtl/gppcu_instr_issue_pkg.sv
// Shared definitions for the GPPCU instruction issue sequencer: opcode field
// geometry, a few well-known opcodes and the sequencer state type.
package gppcu_instr_issue_pkg;

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] NOP   = 5'd0;
  localparam logic [OPC_W-1:0] FADD  = 5'd1;
  localparam logic [OPC_W-1:0] FSUB  = 5'd2;
  localparam logic [OPC_W-1:0] FMUL  = 5'd3;
  localparam logic [OPC_W-1:0] FDIV  = 5'd4;
  localparam logic [OPC_W-1:0] FSQRT = 5'd5;

  typedef enum logic [1:0] {
    ISS_IDLE,
    ISS_RUN,
    ISS_DONE
  } iss_state_t;

endpackage

// File: rtl/gppcu_issue_fifo.sv
// Small synchronous FIFO holding fetched instruction words until the lanes
// accept them. DEPTH must be a power of two so the pointers wrap naturally.
module gppcu_issue_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 32,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/gppcu_instr_issue.sv
// Fetch/issue sequencer: streams iLEN instruction words from instruction
// memory into the decoder, one per cycle, honouring lane backpressure.
module gppcu_instr_issue
  import gppcu_instr_issue_pkg::*;
#(
  parameter int unsigned AW        = 10,
  parameter int unsigned IW        = 32,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iSTART,
  input  logic                iABORT,
  input  logic [AW:0]         iLEN,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oIMEM_RD,
  output logic [AW-1:0]       oIMEM_ADDR,
  input  logic [IW-1:0]       iIMEM_DATA,
  input  logic                iSTALL,
  output logic                oISSUE,
  output logic [OPC_W-1:0]    oOPC,
  output logic [IW-OPC_W-1:0] oOPERAND,
  output logic [AW-1:0]       oPC
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  iss_state_t    state;
  logic [AW:0]   fpc;
  logic [AW:0]   issued;
  logic [AW:0]   len;
  logic          inflight;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] count;
  logic [IW-1:0] head;
  logic          pop;
  logic          rd;
  logic          last_pop;
  logic [OW-1:0] occupancy;

  gppcu_issue_fifo #(
    .DEPTH (BUF_DEPTH),
    .W     (IW),
    .CW    (CW)
  ) u_fifo (
    .clk   (iCLK),
    .rst_n (iRST_n),
    .push  (inflight),
    .pop   (pop),
    .flush (iABORT),
    .din   (iIMEM_DATA),
    .head  (head),
    .count (count)
  );

  // Occupancy counts the word already in flight so a stall can never overflow the buffer.
  always_comb begin
    pop       = (state == ISS_RUN) && (count != '0) && !iSTALL;
    occupancy = {1'b0, count} + OW'(inflight) - OW'(pop);
    rd        = (state == ISS_RUN) && (fpc < len) && (occupancy < OW'(BUF_DEPTH));
    last_pop  = pop && ((issued + 1'b1) == len);
  end

  always_comb begin
    oIMEM_RD   = rd;
    oIMEM_ADDR = rd ? fpc[AW-1:0] : '0;
    oISSUE     = pop;
    oOPC       = pop ? head[IW-1 -: OPC_W] : NOP;
    oOPERAND   = pop ? head[IW-OPC_W-1:0] : '0;
    oPC        = pop ? issued[AW-1:0] : '0;
    oBUSY      = busy_q;
    oDONE      = done_q;
  end

  // Leaving RUN on the final pop is equivalent to waiting for issued==len with
  // an empty pipe (everything was fetched before it could issue), one cycle earlier.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state    <= ISS_IDLE;
      fpc      <= '0;
      issued   <= '0;
      len      <= '0;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (iABORT) begin
      state    <= ISS_IDLE;
      inflight <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inflight <= rd;
      if (rd)  fpc    <= fpc + 1'b1;
      if (pop) issued <= issued + 1'b1;
      unique case (state)
        ISS_IDLE: begin
          done_q <= 1'b0;
          if (iSTART) begin
            len    <= iLEN;
            fpc    <= '0;
            issued <= '0;
            if (iLEN != '0) begin
              state  <= ISS_RUN;
              busy_q <= 1'b1;
            end else begin
              state  <= ISS_DONE;
              done_q <= 1'b1;
            end
          end
        end
        ISS_RUN: begin
          if (last_pop) begin
            state  <= ISS_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ISS_DONE: begin
          done_q <= 1'b0;
          state  <= ISS_IDLE;
        end
        default: state <= ISS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gppcu_instr_issue.sv
// Self-checking bench for gppcu_instr_issue: the expected issue stream is the
// program memory read in address order, compared against a monitored log.
module tb_gppcu_instr_issue;

  localparam int AW = 4;
  localparam int IW = 32;
  localparam int BD = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          stall = 1'b0;
  logic [AW:0]   ilen = '0;
  logic          busy, done, imem_rd, issue;
  logic [AW-1:0] imem_addr, pc;
  logic [IW-1:0] imem_data = '0;
  logic [4:0]    opc;
  logic [IW-6:0] operand;

  always #5 clk = ~clk;

  gppcu_instr_issue #(.AW(AW), .IW(IW), .BUF_DEPTH(BD)) dut (
    .iCLK(clk), .iRST_n(rst_n), .iSTART(start), .iABORT(abort), .iLEN(ilen),
    .oBUSY(busy), .oDONE(done), .oIMEM_RD(imem_rd), .oIMEM_ADDR(imem_addr),
    .iIMEM_DATA(imem_data), .iSTALL(stall), .oISSUE(issue), .oOPC(opc),
    .oOPERAND(operand), .oPC(pc)
  );

  logic [IW-1:0] mem [16];
  always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int n_issue, n_rd, n_done, addr_viol, occ_viol, stall_viol, nop_viol;
  int first_rd_cyc, first_issue_cyc, last_issue_cyc, done_cyc, cur_len, start_cyc;
  logic busy_at_start;
  logic [AW+IW-1:0] issue_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (imem_rd) begin
          if (n_rd == 0) first_rd_cyc = cyc;
          n_rd++;
          if (int'(imem_addr) >= cur_len) addr_viol++;
        end
        if (issue) begin
          if (stall) stall_viol++;
          if (n_issue == 0) first_issue_cyc = cyc;
          last_issue_cyc = cyc;
          n_issue++;
          issue_q.push_back({pc, opc, operand});
        end else if (opc != 5'd0 || operand != '0) begin
          nop_viol++;
        end
        if (n_rd - n_issue > BD) occ_viol++;
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    n_issue = 0; n_rd = 0; n_done = 0; addr_viol = 0; occ_viol = 0;
    stall_viol = 0; nop_viol = 0; first_rd_cyc = -1; first_issue_cyc = -1;
    last_issue_cyc = -1; done_cyc = -1;
    issue_q.delete();
  endtask

  // mode 0: no stall, 1: random stall, 2: stall 5 cycles after first issue
  task automatic run_prog(input int len, input int mode, input bit glitch, output bit to);
    int stall_cyc = 0;
    @(posedge clk); #1;
    clear_mon();
    cur_len = len;
    start = 1'b1; ilen = (AW+1)'(len); start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; ilen = (AW+1)'($urandom);
    @(negedge clk); busy_at_start = busy;
    for (int k = 0; k < 600 && n_done == 0; k++) begin
      @(posedge clk); #1;
      case (mode)
        1: stall = 1'($urandom_range(0, 1));
        2: begin
          stall = (n_issue >= 1 && stall_cyc < 5);
          if (stall) stall_cyc++;
        end
        default: stall = 1'b0;
      endcase
      start = glitch && (k == 3);
      if (glitch && k == 3) ilen = (AW+1)'(2);
    end
    stall = 1'b0; start = 1'b0;
    to = (n_done == 0);
  endtask

  task automatic test_reset();
    logic [63:0] outs;
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = 64'({imem_rd, imem_addr, issue, opc, operand, pc, busy, done});
    checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h, want 0", outs);
    if (outs !== '0) errors++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    outs = 64'({imem_rd, imem_addr, issue, opc, operand, pc, busy, done});
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_after_reset: got %h, want 0", outs); end
  endtask

  task automatic test_basic();
    bit to;
    logic [AW+IW-1:0] got, exp;
    mem[0] = 32'h08000001; mem[1] = 32'h10000002; mem[2] = 32'h18000003; mem[3] = 32'h00000000;
    run_prog(4, 0, 0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: no oDONE within budget"); end
    checks++; if (n_issue !== 4) begin errors++; $display("FAIL basic_issues: got %0d, want 4", n_issue); end
    for (int i = 0; i < 4; i++) begin
      got = (i < issue_q.size()) ? issue_q[i] : 'x;
      exp = {4'(i), mem[i]};
      checks++; if (got !== exp) begin errors++; $display("FAIL basic_seq[%0d]: got %h, want %h", i, got, exp); end
    end
    checks++; if (n_rd !== 4) begin errors++; $display("FAIL basic_reads: got %0d, want 4", n_rd); end
    checks++; if (last_issue_cyc - first_issue_cyc !== 3) begin errors++; $display("FAIL basic_back_to_back: span %0d, want 3", last_issue_cyc - first_issue_cyc); end
    checks++; if (first_issue_cyc - first_rd_cyc !== 2) begin errors++; $display("FAIL basic_latency: got %0d, want 2", first_issue_cyc - first_rd_cyc); end
    checks++; if (done_cyc !== last_issue_cyc + 1 || n_done !== 1) begin errors++; $display("FAIL basic_done: done_cyc %0d n_done %0d, want %0d and 1", done_cyc, n_done, last_issue_cyc + 1); end
    checks++; if (busy_at_start !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b, want 1", busy_at_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b, want 0", busy); end
  endtask

  task automatic test_stall();
    bit to;
    logic [AW+IW-1:0] got, exp;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    run_prog(3, 2, 0, to);
    checks++; if (to || n_issue !== 3) begin errors++; $display("FAIL stall_issues: got %0d timeout %b, want 3", n_issue, to); end
    for (int i = 0; i < 3; i++) begin
      got = (i < issue_q.size()) ? issue_q[i] : 'x;
      exp = {4'(i), mem[i]};
      checks++; if (got !== exp) begin errors++; $display("FAIL stall_seq[%0d]: got %h, want %h", i, got, exp); end
    end
    checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_issue_while_stalled: got %0d, want 0", stall_viol); end
    checks++; if (occ_viol !== 0 || n_rd !== 3) begin errors++; $display("FAIL stall_buffer: overfill %0d reads %0d, want 0 and 3", occ_viol, n_rd); end
  endtask

  task automatic test_zero_len();
    bit to;
    run_prog(0, 0, 0, to);
    checks++; if (to || done_cyc !== start_cyc + 1) begin errors++; $display("FAIL zero_done: done_cyc %0d, want %0d", done_cyc, start_cyc + 1); end
    checks++; if (n_rd !== 0) begin errors++; $display("FAIL zero_reads: got %0d, want 0", n_rd); end
    checks++; if (busy_at_start !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b, want 0", busy_at_start); end
  endtask

  task automatic test_abort();
    bit to;
    logic [AW+IW-1:0] got, exp;
    int budget;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    clear_mon(); cur_len = 4; stall = 1'b1;
    start = 1'b1; ilen = 5'd4;
    @(posedge clk); #1 start = 1'b0;
    budget = 0;
    while (n_rd < 2 && budget < 20) begin @(negedge clk); budget++; end
    checks++; if (n_rd < 2) begin errors++; $display("FAIL abort_setup: reads %0d, want 2", n_rd); end
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1; ilen = 5'd3;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0; stall = 1'b0;
    @(negedge clk);
    checks++; if ({issue, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_outputs: issue/busy/done %b, want 000", {issue, busy, done}); end
    repeat (6) @(negedge clk);
    checks++; if (n_issue !== 0 || n_done !== 0 || n_rd !== 2) begin errors++; $display("FAIL abort_quiet: issues %0d done %0d reads %0d, want 0 0 2", n_issue, n_done, n_rd); end
    run_prog(2, 0, 0, to);
    checks++; if (to || n_issue !== 2) begin errors++; $display("FAIL abort_rerun: got %0d, want 2", n_issue); end
    for (int i = 0; i < 2; i++) begin
      got = (i < issue_q.size()) ? issue_q[i] : 'x;
      exp = {4'(i), mem[i]};
      checks++; if (got !== exp) begin errors++; $display("FAIL abort_rerun_seq[%0d]: got %h, want %h", i, got, exp); end
    end
  endtask

  task automatic test_async_reset();
    bit to;
    logic [63:0] outs;
    int rd_before;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    @(posedge clk); #1;
    clear_mon(); cur_len = 8;
    start = 1'b1; ilen = 5'd8;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL areset_pre_busy: got %b, want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    outs = 64'({imem_rd, imem_addr, issue, opc, operand, pc, busy, done});
    checks++; if (outs !== '0) begin errors++; $display("FAIL areset_outputs: got %h, want 0", outs); end
    @(posedge clk); @(negedge clk); #1 rst_n = 1'b1;
    rd_before = n_rd;
    repeat (4) @(negedge clk);
    checks++; if (n_rd !== rd_before || busy !== 1'b0 || n_issue > 8) begin errors++; $display("FAIL areset_idle: reads %0d busy %b, want %0d and 0", n_rd, busy, rd_before); end
    run_prog(3, 0, 0, to);
    checks++; if (to || n_issue !== 3 || issue_q.size() < 1 || issue_q[0] !== {4'd0, mem[0]}) begin errors++; $display("FAIL areset_restart: issues %0d timeout %b, want 3", n_issue, to); end
  endtask

  task automatic test_max_len();
    bit to;
    logic [AW+IW-1:0] got, exp;
    int bad;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_prog(16, 1, 0, to);
      checks++; if (to || n_issue !== 16 || n_rd !== 16) begin errors++; $display("FAIL max_counts: issues %0d reads %0d, want 16 16", n_issue, n_rd); end
      bad = 0;
      for (int i = 0; i < 16; i++) begin
        got = (i < issue_q.size()) ? issue_q[i] : 'x;
        exp = {4'(i), mem[i]};
        if (got !== exp) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL max_seq: %0d wrong entries, want 0", bad); end
      checks++; if (addr_viol !== 0 || occ_viol !== 0 || stall_viol !== 0 || nop_viol !== 0) begin
        errors++; $display("FAIL max_rules: addr %0d occ %0d stall %0d nop %0d, want 0", addr_viol, occ_viol, stall_viol, nop_viol);
      end
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [AW+IW-1:0] got, exp;
    int bad;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    run_prog(5, 1, 1, to);
    checks++; if (to || n_issue !== 5 || n_done !== 1) begin errors++; $display("FAIL restart_ignored: issues %0d done %0d, want 5 1", n_issue, n_done); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      got = (i < issue_q.size()) ? issue_q[i] : 'x;
      exp = {4'(i), mem[i]};
      if (got !== exp) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL restart_seq: %0d wrong entries, want 0", bad); end
  endtask

  initial begin
    clear_mon();
    cur_len = 0;
    start_cyc = 0;
    busy_at_start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_abort();
    test_async_reset();
    test_max_len();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
